// File: rtl/upc_isa_pkg.sv
// rtl/upc_isa_pkg.sv - shared opcode constants, class helpers and hazard FSM state type
//
// Purpose: single source of truth for the opcode encodings the hazard logic
// decodes, the small classification functions built on them, and the state
// type of the hazard sequencer.
// Ports: none (package).
package upc_isa_pkg;

  localparam int OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_NOP  = 7'h00;
  localparam logic [OPC_W-1:0] OP_MUL  = 7'h02;
  localparam logic [OPC_W-1:0] OP_LDW  = 7'h10;
  localparam logic [OPC_W-1:0] OP_LDB  = 7'h11;
  localparam logic [OPC_W-1:0] OP_STW  = 7'h12;
  localparam logic [OPC_W-1:0] OP_STB  = 7'h13;
  localparam logic [OPC_W-1:0] OP_BEQ  = 7'h30;
  localparam logic [OPC_W-1:0] OP_JUMP = 7'h31;

  // Forwarding select encodings for the execute-stage operand muxes.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hazard_state_t;

  function automatic logic is_load(input logic [OPC_W-1:0] op);
    return (op == OP_LDW) || (op == OP_LDB);
  endfunction

  function automatic logic is_mem(input logic [OPC_W-1:0] op);
    return is_load(op) || (op == OP_STW) || (op == OP_STB);
  endfunction

  // Everything except bubbles, stores and control transfers produces a result.
  function automatic logic writes_reg(input logic [OPC_W-1:0] op);
    return !((op == OP_NOP) || (op == OP_STW) || (op == OP_STB) ||
             (op == OP_BEQ) || (op == OP_JUMP));
  endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// rtl/hazard_fwd_mux.sv - forwarding source compare for one execute operand
//
// Purpose: picks where one execute-stage operand comes from: register file,
// the M-stage result or the W-stage result. M wins over W because it is the
// younger producer. A load in M has no data yet, so it is never an M source.
// Ports:
//   i_src    in  execute source register index
//   i_m_dst  in  destination index of the instruction in M (0 = none)
//   i_m_load in  instruction in M is a load
//   i_w_dst  in  destination index of the instruction in W (0 = none)
//   o_sel    out 0 = regfile, 1 = M result, 2 = W result
module hazard_fwd_mux
  import upc_isa_pkg::*;
#(
  parameter int REG_IDX_W = 6
) (
  input  logic [REG_IDX_W-1:0] i_src,
  input  logic [REG_IDX_W-1:0] i_m_dst,
  input  logic                 i_m_load,
  input  logic [REG_IDX_W-1:0] i_w_dst,
  output logic [1:0]           o_sel
);

  logic w_src_live;
  logic w_m_hit;
  logic w_w_hit;

  // r0 is hardwired zero, so it never matches a producer.
  assign w_src_live = (i_src != '0);
  assign w_m_hit    = w_src_live && (i_src == i_m_dst) && !i_m_load;
  assign w_w_hit    = w_src_live && (i_src == i_w_dst);

  always_comb begin
    o_sel = FWD_RF;
    if (w_m_hit) begin
      o_sel = FWD_M;
    end else if (w_w_hit) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: stalls, bubbles, squashes and forwarding
//
// Purpose: control partner of the D->X and X->M pipeline registers. Tracks
// the destinations of instructions in M and W, selects execute operand
// forwarding, and sequences load-use, multiply and data-memory-wait stalls.
// Ports:
//   clock, reset_n                    pipeline clock, async active-low reset
//   d_opcode, d_src_reg_1/2           decode-stage opcode and sources
//   x_opcode, x_dst_reg, x_src_reg_1/2 execute-stage fields
//   x_branch_taken                    execute resolved a taken redirect
//   dmem_ready                        M-stage memory access completes
//   f_stall, d_stall, x_stall, m_stall hold PC / F->D / D->X / X->M
//   d2x_flush, f2d_flush              load a bubble into D->X / F->D
//   fwd_sel_1, fwd_sel_2              execute operand sources (0 RF, 1 M, 2 W)
module hazard_ctrl
  import upc_isa_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int REG_IDX_W   = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [OPC_W-1:0]     d_opcode,
  input  logic [REG_IDX_W-1:0] d_src_reg_1,
  input  logic [REG_IDX_W-1:0] d_src_reg_2,
  input  logic [OPC_W-1:0]     x_opcode,
  input  logic [REG_IDX_W-1:0] x_dst_reg,
  input  logic [REG_IDX_W-1:0] x_src_reg_1,
  input  logic [REG_IDX_W-1:0] x_src_reg_2,
  input  logic                 x_branch_taken,
  input  logic                 dmem_ready,
  output logic                 f_stall,
  output logic                 d_stall,
  output logic                 x_stall,
  output logic                 m_stall,
  output logic                 d2x_flush,
  output logic                 f2d_flush,
  output logic [1:0]           fwd_sel_1,
  output logic [1:0]           fwd_sel_2
);

  localparam int              CNT_W    = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hazard_state_t           r_state;
  hazard_state_t           r_prior;
  logic [CNT_W-1:0]        r_mul_cnt;
  logic [REG_IDX_W-1:0]    r_m_dst;
  logic [REG_IDX_W-1:0]    r_w_dst;
  logic                    r_m_load;
  logic                    r_m_mem;

  hazard_state_t           w_state_nxt;
  hazard_state_t           w_prior_nxt;
  hazard_state_t           w_eff_state;
  logic [CNT_W-1:0]        w_mul_cnt_nxt;
  logic                    w_mem_hold;
  logic                    w_load_use;
  logic                    w_mul_busy;
  logic                    w_f_stall;
  logic                    w_d_stall;
  logic                    w_x_stall;
  logic                    w_m_stall;
  logic                    w_d2x_flush;
  logic                    w_f2d_flush;

  // M-stage access not yet acknowledged: everything upstream must freeze.
  assign w_mem_hold = r_m_mem && !dmem_ready;

  // On the cycle memory releases, behave as the state we were parked from.
  assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_prior : r_state;

  // A decode bubble reads no registers, so it cannot be a load-use consumer.
  assign w_load_use = is_load(x_opcode) && (x_dst_reg != '0) && (d_opcode != OP_NOP) &&
                      ((x_dst_reg == d_src_reg_1) || (x_dst_reg == d_src_reg_2));

  // X stays held while the decremented count is still non-zero, so the MUL
  // leaves X on the MUL_LATENCY-th cycle it has spent there.
  assign w_mul_busy = (r_mul_cnt > CNT_ONE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RUN;
      r_prior   <= ST_RUN;
      r_mul_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_prior   <= w_prior_nxt;
      r_mul_cnt <= w_mul_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt   = w_eff_state;
    w_prior_nxt   = r_prior;
    w_mul_cnt_nxt = r_mul_cnt;
    if (w_mem_hold) begin
      // Count is left untouched so a pending MUL resumes where it stopped.
      w_state_nxt = ST_MEM_WAIT;
      w_prior_nxt = w_eff_state;
    end else begin
      case (w_eff_state)
        ST_RUN: begin
          if ((x_opcode == OP_MUL) && !x_branch_taken) begin
            w_state_nxt   = ST_MUL_WAIT;
            w_mul_cnt_nxt = MUL_LOAD;
          end
        end
        ST_MUL_WAIT: begin
          if (w_mul_busy) begin
            w_mul_cnt_nxt = r_mul_cnt - CNT_ONE;
          end else begin
            w_state_nxt   = ST_RUN;
            w_mul_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt   = ST_RUN;
          w_mul_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output logic. Redirect is checked before any RUN-state stall so that a
  // squash never coincides with a held D->X register.
  always_comb begin
    w_f_stall   = 1'b0;
    w_d_stall   = 1'b0;
    w_x_stall   = 1'b0;
    w_m_stall   = 1'b0;
    w_d2x_flush = 1'b0;
    w_f2d_flush = 1'b0;
    if (w_mem_hold) begin
      w_f_stall = 1'b1;
      w_d_stall = 1'b1;
      w_x_stall = 1'b1;
      w_m_stall = 1'b1;
    end else begin
      case (w_eff_state)
        ST_RUN: begin
          if (x_branch_taken) begin
            w_f2d_flush = 1'b1;
            w_d2x_flush = 1'b1;
          end else if (x_opcode == OP_MUL) begin
            w_f_stall = 1'b1;
            w_d_stall = 1'b1;
            w_x_stall = 1'b1;
          end else if (w_load_use) begin
            w_f_stall   = 1'b1;
            w_d_stall   = 1'b1;
            w_d2x_flush = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          w_f_stall = w_mul_busy;
          w_d_stall = w_mul_busy;
          w_x_stall = w_mul_busy;
        end
        default: begin
          w_f_stall = 1'b0;
        end
      endcase
    end
  end

  assign f_stall   = reset_n & w_f_stall;
  assign d_stall   = reset_n & w_d_stall;
  assign x_stall   = reset_n & w_x_stall;
  assign m_stall   = reset_n & w_m_stall;
  assign d2x_flush = reset_n & w_d2x_flush;
  assign f2d_flush = reset_n & w_f2d_flush;

  // M/W destination tracking. A held X stage sends a bubble into M.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_m_dst  <= '0;
      r_w_dst  <= '0;
      r_m_load <= 1'b0;
      r_m_mem  <= 1'b0;
    end else if (!w_m_stall) begin
      if (w_x_stall) begin
        r_m_dst  <= '0;
        r_m_load <= 1'b0;
        r_m_mem  <= 1'b0;
      end else begin
        r_m_dst  <= writes_reg(x_opcode) ? x_dst_reg : '0;
        r_m_load <= is_load(x_opcode);
        r_m_mem  <= is_mem(x_opcode);
      end
      r_w_dst <= r_m_dst;
    end
  end

  hazard_fwd_mux #(.REG_IDX_W(REG_IDX_W)) u_fwd_1 (
    .i_src    (x_src_reg_1),
    .i_m_dst  (r_m_dst),
    .i_m_load (r_m_load),
    .i_w_dst  (r_w_dst),
    .o_sel    (fwd_sel_1)
  );

  hazard_fwd_mux #(.REG_IDX_W(REG_IDX_W)) u_fwd_2 (
    .i_src    (x_src_reg_2),
    .i_m_dst  (r_m_dst),
    .i_m_load (r_m_load),
    .i_w_dst  (r_w_dst),
    .o_sel    (fwd_sel_2)
  );

endmodule
